// File: rtl/sar_seq_ctrl.sv
// Sample/convert sequencer for the time-domain SAR ADC.
// Drives samp/start per channel, round-robins channels, and handles timeout and trigger queuing.
module sar_seq_ctrl #(
  parameter int SAMP_CYC    = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int NCH         = 4,
  parameter int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            cont,
  input  logic            trig,
  input  logic            eoc,
  output logic            samp,
  output logic            start,
  output logic [CH_W-1:0] ch,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [CH_W-1:0] done_ch
);

  localparam int CNT_MAX = (SAMP_CYC > TIMEOUT_CYC) ? SAMP_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMP_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMP,
    ST_CONV,
    ST_RELEASE
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              pending, pending_nx;
  logic [CH_W-1:0]   ch_nx, done_ch_nx;
  logic              samp_nx, start_nx, busy_nx, done_nx, timeout_nx;
  logic              req, go;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pending_nx = pending;
    ch_nx      = ch;
    done_ch_nx = done_ch;
    samp_nx    = 1'b0;
    start_nx   = 1'b0;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    go         = 1'b0;
    req        = cont | trig | pending;

    case (state)
      ST_IDLE: begin
        if (req && !eoc) go = 1'b1;
      end

      ST_SAMP: begin
        samp_nx = 1'b1;
        if (cnt == SAMP_LAST) begin
          state_nx = ST_CONV;
          cnt_nx   = '0;
          samp_nx  = 1'b0;
          start_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      // eoc is checked before the timeout so a simultaneous eoc wins.
      ST_CONV: begin
        start_nx = 1'b1;
        if (eoc) begin
          start_nx   = 1'b0;
          done_nx    = 1'b1;
          done_ch_nx = ch;
          state_nx   = ST_RELEASE;
          cnt_nx     = '0;
        end else if (cnt == CONV_LAST) begin
          start_nx   = 1'b0;
          timeout_nx = 1'b1;
          done_ch_nx = ch;
          state_nx   = ST_RELEASE;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!eoc) begin
          ch_nx = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
          if (req) go = 1'b1;
          else     state_nx = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase

    // A trigger that does not launch a conversion right now is remembered once.
    if (go) begin
      state_nx   = ST_SAMP;
      samp_nx    = 1'b1;
      cnt_nx     = '0;
      pending_nx = 1'b0;
    end else if (trig && !cont) begin
      pending_nx = 1'b1;
    end

    if (!en) begin
      state_nx   = ST_IDLE;
      cnt_nx     = '0;
      pending_nx = 1'b0;
      ch_nx      = '0;
      done_ch_nx = done_ch;
      samp_nx    = 1'b0;
      start_nx   = 1'b0;
      done_nx    = 1'b0;
      timeout_nx = 1'b0;
    end

    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= 1'b0;
      ch      <= '0;
      done_ch <= '0;
      samp    <= 1'b0;
      start   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
      ch      <= ch_nx;
      done_ch <= done_ch_nx;
      samp    <= samp_nx;
      start   <= start_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      timeout <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Directed bench for sar_seq_ctrl with SAMP_CYC=3, TIMEOUT_CYC=16, NCH=4.
// A vector table covers single-shot; hand sequences cover reset, round-robin, timeout, abort and eoc blocking.
module tb_sar_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cont, trig, eoc;
  logic       samp, start, busy, done, timeout;
  logic [1:0] ch, done_ch;

  int checks = 0;
  int errors = 0;

  // in = {rst,en,cont,trig,eoc}; flags = {samp,start,busy,done,timeout}
  typedef struct {
    logic [4:0] in;
    logic [4:0] flags;
    logic [1:0] ch;
    logic [1:0] dch;
  } vec_t;

  vec_t vecs[13];

  sar_seq_ctrl #(
    .SAMP_CYC   (3),
    .TIMEOUT_CYC(16),
    .NCH        (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .cont   (cont),
    .trig   (trig),
    .eoc    (eoc),
    .samp   (samp),
    .start  (start),
    .ch     (ch),
    .busy   (busy),
    .done   (done),
    .timeout(timeout),
    .done_ch(done_ch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] in);
    {rst, en, cont, trig, eoc} = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkOutput("no_overlap", 32'(samp & start), 32'd0);
  endtask

  function automatic logic [4:0] flagsNow();
    return {samp, start, busy, done, timeout};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int  ndone;
    int  lastDone;
    int  n;
    logic lastStart;

    vecs[0]  = '{5'b10000, 5'b00000, 2'd0, 2'd0};
    vecs[1]  = '{5'b01010, 5'b10100, 2'd0, 2'd0};
    vecs[2]  = '{5'b01000, 5'b10100, 2'd0, 2'd0};
    vecs[3]  = '{5'b01000, 5'b10100, 2'd0, 2'd0};
    vecs[4]  = '{5'b01000, 5'b01100, 2'd0, 2'd0};
    vecs[5]  = '{5'b01000, 5'b01100, 2'd0, 2'd0};
    vecs[6]  = '{5'b01000, 5'b01100, 2'd0, 2'd0};
    vecs[7]  = '{5'b01000, 5'b01100, 2'd0, 2'd0};
    vecs[8]  = '{5'b01000, 5'b01100, 2'd0, 2'd0};
    vecs[9]  = '{5'b01001, 5'b00110, 2'd0, 2'd0};
    vecs[10] = '{5'b01001, 5'b00100, 2'd0, 2'd0};
    vecs[11] = '{5'b01000, 5'b00000, 2'd1, 2'd0};
    vecs[12] = '{5'b01000, 5'b00000, 2'd1, 2'd0};

    applyStimulus(5'b10000);
    step();

    // Single shot from the table.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].in);
      step();
      checkOutput($sformatf("row%0d_flags", i), 32'(flagsNow()), 32'(vecs[i].flags));
      checkOutput($sformatf("row%0d_ch", i), 32'(ch), 32'(vecs[i].ch));
      checkOutput($sformatf("row%0d_done_ch", i), 32'(done_ch), 32'(vecs[i].dch));
    end

    // Reset held for 3 cycles during CONV, with eoc high.
    applyStimulus(5'b01010);
    step();
    applyStimulus(5'b01000);
    step(); step(); step();
    checkOutput("rst_pre_start", 32'(start), 32'd1);
    applyStimulus(5'b11001);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("rst%0d_flags", i), 32'(flagsNow()), 32'd0);
      checkOutput($sformatf("rst%0d_ch", i), 32'(ch), 32'd0);
      checkOutput($sformatf("rst%0d_done_ch", i), 32'(done_ch), 32'd0);
    end
    applyStimulus(5'b01000);
    step();
    checkOutput("post_rst_flags", 32'(flagsNow()), 32'd0);
    checkOutput("post_rst_ch", 32'(ch), 32'd0);

    // Continuous round-robin with an ideal SAR.
    applyStimulus(5'b01100);
    ndone = 0;
    lastDone = -1;
    lastStart = 1'b0;
    for (int c = 0; c < 200 && ndone < 9; c++) begin
      step();
      if (done) begin
        checkOutput($sformatf("cont_done_ch%0d", ndone), 32'(done_ch), 32'(ndone % 4));
        if (ndone > 0) checkOutput($sformatf("cont_period%0d", ndone), 32'(c - lastDone), 32'd6);
        lastDone = c;
        ndone++;
      end
      eoc = start & lastStart;
      lastStart = start;
    end
    checkOutput("cont_count", 32'(ndone), 32'd9);
    applyStimulus(5'b00000);
    step();
    checkOutput("cont_stop_flags", 32'(flagsNow()), 32'd0);
    checkOutput("cont_stop_ch", 32'(ch), 32'd0);
    applyStimulus(5'b11000);
    step();

    // Timeout, then eoc arriving exactly on the expiry cycle.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(5'b01010);
      step();
      applyStimulus(5'b01000);
      step(); step(); step();
      n = 0;
      while (start && n < 40) begin
        n++;
        eoc = (r == 1) && (n == 16);
        step();
      end
      eoc = 1'b0;
      checkOutput($sformatf("to%0d_start_len", r), 32'(n), 32'd16);
      checkOutput($sformatf("to%0d_timeout", r), 32'(timeout), 32'(r == 0));
      checkOutput($sformatf("to%0d_done", r), 32'(done), 32'(r == 1));
      checkOutput($sformatf("to%0d_done_ch", r), 32'(done_ch), 32'(r));
      step();
      checkOutput($sformatf("to%0d_after_flags", r), 32'(flagsNow()), 32'd0);
      checkOutput($sformatf("to%0d_after_ch", r), 32'(ch), 32'(r + 1));
    end

    // Enable drop during SAMP on channel 2.
    applyStimulus(5'b01010);
    step();
    checkOutput("abort_pre_ch", 32'(ch), 32'd2);
    checkOutput("abort_pre_samp", 32'(samp), 32'd1);
    applyStimulus(5'b01000);
    step();
    applyStimulus(5'b00000);
    step();
    checkOutput("abort_flags", 32'(flagsNow()), 32'd0);
    checkOutput("abort_ch", 32'(ch), 32'd0);
    applyStimulus(5'b01000);
    step();

    // Three trigger pulses around one conversion give exactly two conversions.
    ndone = 0;
    lastStart = 1'b0;
    for (int j = 0; j < 40; j++) begin
      trig = (j == 0) || (j == 2) || (j == 4);
      step();
      if (done) begin
        checkOutput($sformatf("pend_done_ch%0d", ndone), 32'(done_ch), 32'(ndone));
        ndone++;
      end
      eoc = start & lastStart;
      lastStart = start;
    end
    trig = 1'b0;
    eoc  = 1'b0;
    checkOutput("pend_count", 32'(ndone), 32'd2);
    checkOutput("pend_end_busy", 32'(busy), 32'd0);
    checkOutput("pend_end_ch", 32'(ch), 32'd2);

    // eoc high in IDLE blocks a pending trigger until it falls.
    applyStimulus(5'b01011);
    step();
    checkOutput("blk_trig_flags", 32'(flagsNow()), 32'd0);
    applyStimulus(5'b01001);
    step();
    checkOutput("blk_hold0_busy", 32'(busy), 32'd0);
    step();
    checkOutput("blk_hold1_busy", 32'(busy), 32'd0);
    applyStimulus(5'b01000);
    step();
    checkOutput("blk_release_flags", 32'(flagsNow()), 32'b10100);
    checkOutput("blk_release_ch", 32'(ch), 32'd2);
    applyStimulus(5'b00000);
    step();
    checkOutput("blk_abort_flags", 32'(flagsNow()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
